inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache_pkg.sv | 25 ++
 rtl/inst_cache_if.sv | 26 ++
 rtl/inst_cache_line_array.sv | 63 ++++++
 rtl/inst_cache.sv | 122 ++++++++++++
 tb/tb_inst_cache.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/inst_cache_pkg.sv
// Shared widths, FSM state encoding and block word-select helper for the
// direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = 16;
    localparam int OFFSET_W   = $clog2(BLOCK_SIZE);
    localparam int BLOCK_W    = WORD_SIZE * BLOCK_SIZE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_WAIT = 2'd2,
        FILL      = 2'd3
    } state_e;

    // Word 0 of a block sits in the most significant WORD_SIZE bits.
    function automatic logic [WORD_SIZE-1:0] block_word(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        return blk[(BLOCK_SIZE - 1 - int'(off)) * WORD_SIZE +: WORD_SIZE];
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
interface inst_cache_if;
    import inst_cache_pkg::*;

    logic                 req;
    logic [WORD_SIZE-1:0] pc;
    logic                 flush;
    logic [WORD_SIZE-1:0] inst;
    logic                 ready;
    logic                 busy;
    logic [WORD_SIZE-1:0] mem_ptr;
    logic [BLOCK_W-1:0]   mem_block;
    logic [31:0]          hit_count;
    logic [31:0]          miss_count;

    modport slave (
        input  req, pc, flush, mem_block,
        output inst, ready, busy, mem_ptr, hit_count, miss_count
    );

    modport master (
        output req, pc, flush, mem_block,
        input  inst, ready, busy, mem_ptr, hit_count, miss_count
    );

endinterface

// File: rtl/inst_cache_line_array.sv
// Valid/tag/data storage: one write port, one registered read port.
// Valid bits live in flops so flush can clear them all at once.
module inst_cache_line_array
    import inst_cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = WORD_SIZE - OFFSET_W - IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [BLOCK_W-1:0] rd_data_o
);

    logic [NUM_LINES-1:0] valid_q;
    logic [IDX_W-1:0]     rd_idx_q;
    logic [TAG_W-1:0]     tag_mem [NUM_LINES];
    logic [BLOCK_W-1:0]   data_mem [NUM_LINES];
    logic [TAG_W-1:0]     rd_tag_q;
    logic [BLOCK_W-1:0]   rd_data_q;

    // A fill landing in the same cycle as a flush still leaves its line valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rd_idx_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (wr_en_i && (wr_idx_i == IDX_W'(i)))
                    valid_q[i] <= 1'b1;
                else if (flush_i)
                    valid_q[i] <= 1'b0;
            end
            if (rd_en_i)
                rd_idx_q <= rd_idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_tag_q  <= tag_mem[rd_idx_i];
            rd_data_q <= data_mem[rd_idx_i];
        end
    end

    assign rd_valid_o = valid_q[rd_idx_q];
    assign rd_tag_o   = rd_tag_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: FSM, miss wait counter and hit/miss counters.
// The line read is launched on acceptance so LOOKUP sees the line one cycle later.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int NUM_LINES    = 8,
    parameter int MISS_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    inst_cache_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - OFFSET_W - IDX_W;
    localparam int CNT_W = $clog2(MISS_LATENCY + 1);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          hit_q, hit_d;
    logic [31:0]          miss_q, miss_d;

    logic                 rd_en, wr_en, rd_valid, hit;
    logic [TAG_W-1:0]     rd_tag;
    logic [BLOCK_W-1:0]   rd_data;
    logic [WORD_SIZE-1:0] inst_o, mem_ptr_o;
    logic                 ready_o;

    inst_cache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.flush),
        .wr_en_i    (wr_en),
        .wr_idx_i   (pc_q[OFFSET_W +: IDX_W]),
        .wr_tag_i   (pc_q[WORD_SIZE-1 -: TAG_W]),
        .wr_data_i  (bus.mem_block),
        .rd_en_i    (rd_en),
        .rd_idx_i   (bus.pc[OFFSET_W +: IDX_W]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data)
    );

    // A flush coinciding with LOOKUP must force a miss.
    assign hit = rd_valid && !bus.flush && (rd_tag == pc_q[WORD_SIZE-1 -: TAG_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        ready_o   = 1'b0;
        inst_o    = '0;
        mem_ptr_o = {pc_q[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
        unique case (state_q)
            IDLE: begin
                mem_ptr_o = '0;
                if (bus.req) begin
                    pc_d    = bus.pc;
                    rd_en   = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ready_o = 1'b1;
                    inst_o  = block_word(rd_data, pc_q[OFFSET_W-1:0]);
                    hit_d   = hit_q + 32'd1;
                    state_d = IDLE;
                end else begin
                    miss_d  = miss_q + 32'd1;
                    cnt_d   = CNT_W'(MISS_LATENCY);
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = FILL;
            end
            FILL: begin
                wr_en   = 1'b1;
                ready_o = 1'b1;
                inst_o  = block_word(bus.mem_block, pc_q[OFFSET_W-1:0]);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.inst       = inst_o;
    assign bus.ready      = ready_o;
    assign bus.busy       = (state_q != IDLE);
    assign bus.mem_ptr    = mem_ptr_o;
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus random fetches
// compared against a line-level behavioural model.
module tb_inst_cache;
    import inst_cache_pkg::*;

    localparam int NUM_LINES    = 8;
    localparam int MISS_LATENCY = 4;
    localparam int IDX_W        = $clog2(NUM_LINES);

    logic clk = 1'b0;
    logic rst;
    inst_cache_if bus_if ();

    inst_cache #(
        .NUM_LINES    (NUM_LINES),
        .MISS_LATENCY (MISS_LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid [NUM_LINES];
    logic [31:0] m_tag   [NUM_LINES];
    logic [31:0] m_hits;
    logic [31:0] m_miss;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always_comb begin
        bus_if.mem_block = '0;
        for (int i = 0; i < BLOCK_SIZE; i++)
            bus_if.mem_block[(BLOCK_SIZE-1-i)*WORD_SIZE +: WORD_SIZE] = mem_word(bus_if.mem_ptr + 32'(i));
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    endtask

    // Called at a negedge with the cache idle; returns at a negedge, idle again.
    task automatic fetch(input logic [31:0] addr, input bit flush_mid);
        int          idx;
        logic [31:0] tag;
        bit          exp_hit;
        int          exp_lat;
        int          cyc;
        bit          seen;
        bit          did_flush;
        logic [31:0] got_inst;
        idx     = int'((addr >> OFFSET_W) % NUM_LINES);
        tag     = addr >> (OFFSET_W + IDX_W);
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_lat = exp_hit ? 1 : MISS_LATENCY + 2;
        bus_if.req = 1'b1;
        bus_if.pc  = addr;
        @(posedge clk);
        cyc = 0; seen = 0; did_flush = 0; got_inst = '0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_val("mem_ptr", bus_if.mem_ptr, {addr[31:OFFSET_W], 4'b0});
                check_val("busy_inflight", 32'(bus_if.busy), 32'd1);
                bus_if.pc = $urandom;
            end
            if (flush_mid && !exp_hit && cyc == 3) begin
                bus_if.flush = 1'b1;
                did_flush = 1'b1;
            end
            if (cyc == 4) bus_if.flush = 1'b0;
            if (bus_if.ready) begin
                seen = 1'b1;
                got_inst = bus_if.inst;
                check_val("latency", 32'(cyc), 32'(exp_lat));
                check_val("inst", bus_if.inst, mem_word(addr));
            end
        end
        if (!seen) check_val("ready_timeout", 32'd0, 32'd1);
        bus_if.req   = 1'b0;
        bus_if.flush = 1'b0;
        if (did_flush) model_flush();
        if (exp_hit) m_hits++;
        else begin
            m_miss++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
        @(negedge clk);
        check_val("hit_count", bus_if.hit_count, m_hits);
        check_val("miss_count", bus_if.miss_count, m_miss);
        check_val("busy_idle", 32'(bus_if.busy), 32'd0);
        $display("fetch pc=%h %s flush=%0d lat=%0d inst=%h hits=%0d misses=%0d",
                 addr, exp_hit ? "hit " : "miss", did_flush, cyc, got_inst,
                 bus_if.hit_count, bus_if.miss_count);
    endtask

    task automatic fetch_with_reset(input logic [31:0] addr);
        bit rdy_seen;
        rdy_seen = 1'b0;
        bus_if.req = 1'b1;
        bus_if.pc  = addr;
        @(posedge clk);
        @(negedge clk);
        rdy_seen |= bus_if.ready;
        @(negedge clk);
        rdy_seen |= bus_if.ready;
        rst        = 1'b1;
        bus_if.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_val("rst_mid_ready", 32'(rdy_seen | bus_if.ready), 32'd0);
        check_val("rst_mid_busy", 32'(bus_if.busy), 32'd0);
        check_val("rst_mid_ptr", bus_if.mem_ptr, 32'd0);
        check_val("rst_mid_miss", bus_if.miss_count, 32'd0);
        $display("reset during miss pc=%h busy=%0d", addr, bus_if.busy);
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.req   = 1'b0;
        bus_if.pc    = '0;
        bus_if.flush = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(bus_if.ready), 32'd0);
        check_val("rst_busy", 32'(bus_if.busy), 32'd0);
        check_val("rst_inst", bus_if.inst, 32'd0);
        check_val("rst_mem_ptr", bus_if.mem_ptr, 32'd0);
        check_val("rst_hits", bus_if.hit_count, 32'd0);
        check_val("rst_misses", bus_if.miss_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fetch(32'h23, 1'b0);
        fetch(32'h2F, 1'b0);
        fetch(32'h05, 1'b0);
        fetch(32'h85, 1'b0);
        fetch(32'h05, 1'b0);
        fetch(32'h40, 1'b1);
        fetch(32'h40, 1'b0);
        fetch(32'h23, 1'b0);
        fetch(32'h05, 1'b0);
        fetch_with_reset(32'h33);
        fetch(32'h33, 1'b0);
        fetch(32'h33, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                bus_if.flush = 1'b1;
                @(negedge clk);
                bus_if.flush = 1'b0;
                model_flush();
                check_val("busy_after_flush", 32'(bus_if.busy), 32'd0);
                $display("idle flush");
            end else if (r == 1) begin
                @(negedge clk);
                check_val("busy_gap", 32'(bus_if.busy), 32'd0);
                $display("idle gap");
            end else begin
                fetch(32'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
